// File: rtl/eval_sched_pkg.sv
// Shared types and default parameters for the eval datapath scheduler.
package eval_sched_pkg;

    localparam int ID_W          = 1;
    localparam int DEF_LAT       = 2;
    localparam int DEF_IDLE_GATE = 4;

    typedef logic [1:0] state_t;

    localparam state_t S_GATED  = 2'd0;
    localparam state_t S_WAKE   = 2'd1;
    localparam state_t S_ACTIVE = 2'd2;
    localparam state_t S_DRAIN  = 2'd3;

    typedef struct packed {
        logic            valid;
        logic [ID_W-1:0] id;
    } trk_entry_t;

endpackage

// File: rtl/eval_sched_if.sv
// Requester, datapath and response signals of the eval scheduler.
interface eval_sched_if
    import eval_sched_pkg::*;
#(
    parameter int DATA_W = 8
);
    logic              req0_valid;
    logic              req0_ready;
    logic [DATA_W-1:0] req0_a;
    logic [DATA_W-1:0] req0_b;
    logic              req1_valid;
    logic              req1_ready;
    logic [DATA_W-1:0] req1_a;
    logic [DATA_W-1:0] req1_b;
    logic [DATA_W-1:0] dp_data_in1;
    logic [DATA_W-1:0] dp_data_in2;
    logic              dp_kernel_enable;
    logic [DATA_W-1:0] dp_result;
    logic              rsp_valid;
    logic [ID_W-1:0]   rsp_id;
    logic [DATA_W-1:0] rsp_data;

    // Master plays both requesters and the datapath.
    modport master (
        output req0_valid, req0_a, req0_b, req1_valid, req1_a, req1_b, dp_result,
        input  req0_ready, req1_ready, dp_data_in1, dp_data_in2, dp_kernel_enable,
        input  rsp_valid, rsp_id, rsp_data
    );

    modport slave (
        input  req0_valid, req0_a, req0_b, req1_valid, req1_a, req1_b, dp_result,
        output req0_ready, req1_ready, dp_data_in1, dp_data_in2, dp_kernel_enable,
        output rsp_valid, rsp_id, rsp_data
    );
endinterface

// File: rtl/rr_arb2.sv
// Combinational two-way round-robin grant; the last-grant pointer lives in the caller.
module rr_arb2 (
    input  logic [1:0] valid,
    input  logic       ptr,
    input  logic       en,
    output logic [1:0] gnt
);
    // ptr is the id granted last, so on contention the other requester wins.
    assign gnt[0] = en & valid[0] & (~valid[1] | ptr);
    assign gnt[1] = en & valid[1] & (~valid[0] | ~ptr);
endmodule

// File: rtl/eval_sched.sv
// Round-robin issue, in-flight tracking and kernel clock gating for the eval datapath.
// Optional grant/gated-cycle statistics are built when EVAL_SCHED_STATS_EN is defined.
module eval_sched
    import eval_sched_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int LAT       = DEF_LAT,
    parameter int IDLE_GATE = DEF_IDLE_GATE
) (
    input  logic         clk,
    input  logic         rst_n,
    eval_sched_if.slave  bus
`ifdef EVAL_SCHED_STATS_EN
    ,
    output logic [15:0]  stat_grant0,
    output logic [15:0]  stat_grant1,
    output logic [15:0]  stat_gated_cycles
`endif
);

    state_t            state_q, state_d;
    logic [3:0]        idle_q, idle_d;
    logic              ptr_q;
    logic              en_q;
    logic [1:0]        gnt;
    logic              any_req, any_gnt, arb_en, busy;
    trk_entry_t        trk_q [LAT+1];
    logic [DATA_W-1:0] op1_p0, op2_p0;
    logic [DATA_W-1:0] rsp_data_p1;

    assign any_req = bus.req0_valid | bus.req1_valid;
    assign arb_en  = (state_q == S_ACTIVE) || (state_q == S_DRAIN);
    assign any_gnt = |gnt;

    rr_arb2 u_arb (
        .valid ({bus.req1_valid, bus.req0_valid}),
        .ptr   (ptr_q),
        .en    (arb_en),
        .gnt   (gnt)
    );

    assign bus.req0_ready       = gnt[0];
    assign bus.req1_ready       = gnt[1];
    assign bus.dp_kernel_enable = en_q;
    assign bus.dp_data_in1      = op1_p0;
    assign bus.dp_data_in2      = op2_p0;
    assign bus.rsp_valid        = trk_q[LAT].valid;
    assign bus.rsp_id           = trk_q[LAT].id;
    assign bus.rsp_data         = rsp_data_p1;

    // The tail entry is the response stage, so the datapath is idle once it alone is valid.
    always_comb begin
        busy = 1'b0;
        for (int i = 0; i < LAT; i++) busy = busy | trk_q[i].valid;
    end

    always_comb begin
        state_d = state_q;
        idle_d  = idle_q;
        case (state_q)
            S_GATED:  if (any_req) state_d = S_WAKE;
            S_WAKE:   state_d = S_ACTIVE;
            S_ACTIVE: if (!any_req) state_d = S_DRAIN;
            S_DRAIN: begin
                if (any_req) begin
                    state_d = S_ACTIVE;
                end else if (!busy) begin
                    if (idle_q == 4'(IDLE_GATE - 1)) begin
                        state_d = S_GATED;
                        idle_d  = '0;
                    end else begin
                        idle_d = idle_q + 4'd1;
                    end
                end
            end
            default:  state_d = S_GATED;
        endcase
        if (any_gnt) idle_d = '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_GATED;
            idle_q  <= '0;
            ptr_q   <= 1'b1;
            en_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            idle_q  <= idle_d;
            en_q    <= (state_d != S_GATED);
            if (any_gnt) ptr_q <= gnt[1];
        end
    end

    // Issue stage: operands for the datapath.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op1_p0 <= '0;
            op2_p0 <= '0;
        end else if (any_gnt) begin
            op1_p0 <= gnt[1] ? bus.req1_a : bus.req0_a;
            op2_p0 <= gnt[1] ? bus.req1_b : bus.req0_b;
        end
    end

    // In-flight tracker and response stage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i <= LAT; i++) trk_q[i] <= '0;
            rsp_data_p1 <= '0;
        end else if (en_q) begin
            trk_q[0].valid <= any_gnt;
            trk_q[0].id    <= gnt[1];
            for (int i = 1; i <= LAT; i++) trk_q[i] <= trk_q[i-1];
            if (trk_q[LAT-1].valid) rsp_data_p1 <= bus.dp_result;
        end
    end

`ifdef EVAL_SCHED_STATS_EN
    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_grant0       <= '0;
            stat_grant1       <= '0;
            stat_gated_cycles <= '0;
        end else begin
            if (gnt[0])              stat_grant0       <= sat_inc(stat_grant0);
            if (gnt[1])              stat_grant1       <= sat_inc(stat_grant1);
            if (state_q == S_GATED)  stat_gated_cycles <= sat_inc(stat_gated_cycles);
        end
    end
`endif

endmodule

// File: tb/tb_eval_sched.sv
// Directed bench for eval_sched with a one-register adder standing in for the LAT=2 datapath.
module tb_eval_sched;
    import eval_sched_pkg::*;

    localparam int DATA_W = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_cmp = 0;
    int   n_err = 0;
    int   g0, g1;
    logic [7:0] dp_pipe;

    eval_sched_if #(.DATA_W(DATA_W)) bus ();

`ifdef EVAL_SCHED_STATS_EN
    logic [15:0] stat_grant0, stat_grant1, stat_gated_cycles;
`endif

    eval_sched #(.DATA_W(DATA_W), .LAT(2), .IDLE_GATE(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
`ifdef EVAL_SCHED_STATS_EN
        ,
        .stat_grant0       (stat_grant0),
        .stat_grant1       (stat_grant1),
        .stat_gated_cycles (stat_gated_cycles)
`endif
    );

    always #5 clk = ~clk;

    // Datapath stand-in: result = in1 + in2, valid one cycle after the operands appear.
    always @(posedge clk) dp_pipe <= bus.dp_data_in1 + bus.dp_data_in2;
    assign bus.dp_result = dp_pipe;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all_zero(input string pfx);
        check({pfx, "_ready0"}, 16'(bus.req0_ready), 16'h0);
        check({pfx, "_ready1"}, 16'(bus.req1_ready), 16'h0);
        check({pfx, "_rsp_valid"}, 16'(bus.rsp_valid), 16'h0);
        check({pfx, "_rsp_id"}, 16'(bus.rsp_id), 16'h0);
        check({pfx, "_rsp_data"}, 16'(bus.rsp_data), 16'h0);
        check({pfx, "_in1"}, 16'(bus.dp_data_in1), 16'h0);
        check({pfx, "_in2"}, 16'(bus.dp_data_in2), 16'h0);
        check({pfx, "_enable"}, 16'(bus.dp_kernel_enable), 16'h0);
    endtask

    task automatic idle_inputs();
        bus.req0_valid = 1'b0; bus.req0_a = '0; bus.req0_b = '0;
        bus.req1_valid = 1'b0; bus.req1_a = '0; bus.req1_b = '0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic       exp_id [6];
        logic [7:0] exp_d  [6];
        exp_id = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        exp_d  = '{8'h11, 8'h22, 8'h12, 8'h23, 8'h13, 8'h24};

        idle_inputs();
        repeat (3) @(negedge clk);
        #1 check_all_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Single request from GATED: WAKE, grant, issue, response, then gating.
        @(negedge clk);
        bus.req0_valid = 1'b1; bus.req0_a = 8'd3; bus.req0_b = 8'd0;
        #1;
        check("gated_enable", 16'(bus.dp_kernel_enable), 16'h0);
        check("gated_ready0", 16'(bus.req0_ready), 16'h0);
        @(negedge clk); #1;
        check("wake_enable", 16'(bus.dp_kernel_enable), 16'h1);
        check("wake_ready0", 16'(bus.req0_ready), 16'h0);
        @(negedge clk); #1;
        check("first_grant", 16'(bus.req0_ready), 16'h1);
        @(negedge clk);
        bus.req0_valid = 1'b0;
        #1;
        check("issue_in1", 16'(bus.dp_data_in1), 16'h3);
        check("issue_in2", 16'(bus.dp_data_in2), 16'h0);
        @(negedge clk); #1;
        check("rsp_early", 16'(bus.rsp_valid), 16'h0);
        @(negedge clk); #1;
        check("rsp1_valid", 16'(bus.rsp_valid), 16'h1);
        check("rsp1_id", 16'(bus.rsp_id), 16'h0);
        check("rsp1_data", 16'(bus.rsp_data), 16'h3);
        @(negedge clk); #1;
        check("rsp1_strobe", 16'(bus.rsp_valid), 16'h0);
        repeat (2) @(negedge clk);
        #1 check("gate_n6_enable", 16'(bus.dp_kernel_enable), 16'h1);
        @(negedge clk); #1;
        check("gate_n7_enable", 16'(bus.dp_kernel_enable), 16'h0);

        // A request on the last idle cycle keeps the kernel enabled.
        @(negedge clk);
        bus.req1_valid = 1'b1; bus.req1_a = 8'd5; bus.req1_b = 8'd6;
        repeat (2) @(negedge clk);
        #1 check("rewake_grant1", 16'(bus.req1_ready), 16'h1);
        @(negedge clk);
        bus.req1_valid = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check("rsp2_id", 16'(bus.rsp_id), 16'h1);
        check("rsp2_data", 16'(bus.rsp_data), 16'h0B);
        repeat (3) @(negedge clk);
        bus.req0_valid = 1'b1; bus.req0_a = 8'd1; bus.req0_b = 8'd1;
        #1 check("late_grant0", 16'(bus.req0_ready), 16'h1);
        @(negedge clk);
        bus.req0_valid = 1'b0;
        #1 check("late_enable", 16'(bus.dp_kernel_enable), 16'h1);
        repeat (2) @(negedge clk);
        #1;
        check("rsp3_valid", 16'(bus.rsp_valid), 16'h1);
        check("rsp3_id", 16'(bus.rsp_id), 16'h0);
        check("rsp3_data", 16'(bus.rsp_data), 16'h02);

        // Contention: alternating grants starting with requester 0 after reset.
        do_reset();
        g0 = 0; g1 = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            bus.req0_valid = (g0 < 3); bus.req0_a = 8'h10 + 8'(g0); bus.req0_b = 8'h01;
            bus.req1_valid = (g1 < 3); bus.req1_a = 8'h20 + 8'(g1); bus.req1_b = 8'h02;
            #1;
            if (c >= 2 && c <= 7) begin
                check("rr_gnt0", 16'(bus.req0_ready), 16'(exp_id[c-2] == 1'b0));
                check("rr_gnt1", 16'(bus.req1_ready), 16'(exp_id[c-2] == 1'b1));
            end
            if (c >= 5 && c <= 10) begin
                check("rr_rsp_valid", 16'(bus.rsp_valid), 16'h1);
                check("rr_rsp_id", 16'(bus.rsp_id), 16'(exp_id[c-5]));
                check("rr_rsp_data", 16'(bus.rsp_data), 16'(exp_d[c-5]));
            end
            if (bus.req0_ready) g0++;
            if (bus.req1_ready) g1++;
        end
        idle_inputs();
        repeat (5) @(negedge clk);

        // Requester 1 alone: back-to-back grants, requester 0 never readied.
        g1 = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            bus.req1_valid = (c < 6); bus.req1_a = 8'h30 + 8'(g1); bus.req1_b = 8'h0F;
            #1;
            check("solo_ready0", 16'(bus.req0_ready), 16'h0);
            check("solo_ready1", 16'(bus.req1_ready), 16'(c >= 2 && c <= 5));
            if (c >= 5 && c <= 8) begin
                check("solo_rsp_id", 16'(bus.rsp_id), 16'h1);
                check("solo_rsp_data", 16'(bus.rsp_data), 16'(8'h3F + 8'(c - 5)));
            end
            if (bus.req1_ready) g1++;
        end
        idle_inputs();
        repeat (5) @(negedge clk);

        // Reset with two operations in flight.
        @(negedge clk);
        bus.req0_valid = 1'b1; bus.req0_a = 8'h44; bus.req0_b = 8'h55;
        repeat (2) @(negedge clk);
        #1 check("flight_grant_a", 16'(bus.req0_ready), 16'h1);
        @(negedge clk);
        #1 check("flight_grant_b", 16'(bus.req0_ready), 16'h1);
        @(negedge clk);
        bus.req0_valid = 1'b0;
        rst_n = 1'b0;
        #1 check_all_zero("midreset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk); #1;
            check("no_stale_rsp", 16'(bus.rsp_valid), 16'h0);
        end

`ifdef EVAL_SCHED_STATS_EN
        // Five grants to 0 and three to 1, then saturation of a forced counter.
        g0 = 0; g1 = 0;
        for (int c = 0; c < 14; c++) begin
            @(negedge clk);
            bus.req0_valid = (g0 < 5);
            bus.req1_valid = (g1 < 3);
            #1;
            if (bus.req0_ready) g0++;
            if (bus.req1_ready) g1++;
        end
        idle_inputs();
        @(negedge clk); #1;
        check("stat_grant0", stat_grant0, 16'd5);
        check("stat_grant1", stat_grant1, 16'd3);
        force dut.stat_grant0 = 16'hFFFF;
        #1 release dut.stat_grant0;
        g0 = 0;
        for (int c = 0; c < 8 && g0 == 0; c++) begin
            @(negedge clk);
            bus.req0_valid = 1'b1;
            #1;
            if (bus.req0_ready) g0++;
        end
        check("sat_grant_seen", 16'(g0), 16'd1);
        @(negedge clk);
        bus.req0_valid = 1'b0;
        #1;
        check("stat_grant0_sat", stat_grant0, 16'hFFFF);
        check("stat_grant1_hold", stat_grant1, 16'd3);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/eval_sched.md
# eval_sched

Round-robin scheduler and clock-gating controller for the pipelined eval datapath. Two requesters share one datapath through valid/ready handshakes. The scheduler issues at most one operand pair per cycle and tracks in-flight operations through the fixed pipeline latency. It returns each result tagged with the requester id, and drops `kernel_enable` when the datapath has been idle long enough.

## Interface
- `DATA_W`, 8, operand/result width
- `LAT`, 2, datapath latency in cycles from operand presentation to valid `dp_result` (1..4)
- `IDLE_GATE`, 4, consecutive empty cycles before gating (1..15)

- `clk` in 1: single clock
- `rst_n` in 1: reset, asynchronous, active-low
- `req0_valid` in 1: requester 0 has an operand pair
- `req0_ready` out 1: requester 0 handshake accepted this cycle
- `req0_a` in DATA_W: requester 0 operand 1
- `req0_b` in DATA_W: requester 0 operand 2
- `req1_valid`, `req1_ready`, `req1_a`, `req1_b`: same as requester 0, for requester 1
- `dp_data_in1` out DATA_W: registered operand 1 to datapath
- `dp_data_in2` out DATA_W: registered operand 2 to datapath
- `dp_kernel_enable` out 1: datapath pipeline enable (gating control)
- `dp_result` in DATA_W: datapath result
- `rsp_valid` out 1: one-cycle response strobe, no backpressure
- `rsp_id` out 1: requester id of the response
- `rsp_data` out DATA_W: registered `dp_result`

## Operation
- FSM states: GATED (reset state), WAKE, ACTIVE, DRAIN.
  - GATED: `dp_kernel_enable`=0, readies 0. Any `reqX_valid` -> WAKE.
  - WAKE: one cycle, `dp_kernel_enable`=1, readies 0 -> ACTIVE.
  - ACTIVE: `dp_kernel_enable`=1. Arbiter grants one requester per cycle. Goes to DRAIN when no request is present.
  - DRAIN: `dp_kernel_enable`=1. A new request returns to ACTIVE in the same cycle, and the grant is allowed. When the in-flight tracker is empty, the idle counter increments; reaching IDLE_GATE -> GATED. Any grant clears the idle counter.
- Arbitration: round-robin on a last-grant pointer.
  - Both valid: grant the one not last granted.
  - Single valid: grant it.
  - `reqX_ready` is combinational from state, valids and pointer, and is never asserted to a non-valid requester. The pointer updates only on a grant.
  - The pointer resets to 1, so requester 0 wins the first contention.
- Issue: on a grant, the granted `a`/`b` are registered into `dp_data_in1`/`dp_data_in2`. When not issuing, the operand registers hold their values.
- Tracking: a LAT+1 deep shift register of {valid, id}, loaded on each grant.
  - The tail entry valid drives `rsp_valid` and `rsp_id`, with `rsp_data` registered from `dp_result` in the same cycle.
  - The tracker advances every cycle while `dp_kernel_enable`=1. The FSM guarantees it is empty when gated.
- Reset values: readies, `rsp_valid`, `rsp_id`, `rsp_data`, `dp_data_in1`, `dp_data_in2`, `dp_kernel_enable` all 0; tracker empty; idle counter 0.
- Reset asserted mid-operation discards in-flight entries; no response is produced for them.

## Timing
- Handshake in cycle N -> operands on `dp_*` from cycle N+1 -> `rsp_valid` in cycle N+1+LAT.
- Gated to first grant: valid seen in GATED cycle G, WAKE in cycle G+1, earliest grant in cycle G+2.
- Throughput: one operation per cycle while ACTIVE; responses keep issue order.
- Last grant in cycle N, no further requests: GATED entered at cycle N+LAT+1+IDLE_GATE.
- Simultaneous grant and response in one cycle are independent.

## Configuration
- `EVAL_SCHED_STATS_EN` defined: adds outputs `stat_grant0` and `stat_grant1` (16-bit, saturating at 0xFFFF, reset 0) and `stat_gated_cycles` (16-bit, saturating). These count grants per requester and cycles spent in GATED.
- Undefined: these ports and counters are absent; all other behaviour is identical.

## Structure
- Package `eval_sched_pkg`: FSM state enum, `ID_W`=1, tracker entry struct {valid, id}, default LAT and IDLE_GATE constants.
- Sub-module `rr_arb2`: combinational 2-way round-robin grant from valids, pointer and enable. The pointer register stays in `eval_sched`.

## Test plan
- Reset release, `req0_valid`=1 with a=3, b=0: WAKE, then grant. `dp_data_in1`=3 and `dp_data_in2`=0 one cycle after the grant; `rsp_valid`, `rsp_id`=0 at grant+3, with `rsp_data` equal to the modelled datapath output.
- Both requesters valid for 6 cycles: grants alternate 0,1,0,1,0,1; six responses in order with matching ids.
- Only `req1_valid` held for 4 cycles: four consecutive grants to 1, `req0_ready` never asserted.
- Single request then silence with LAT=2, IDLE_GATE=4: `dp_kernel_enable` falls exactly 7 cycles after the grant cycle; a request arriving one cycle earlier keeps it high.
- `rst_n` pulsed low with 2 operations in flight: all outputs 0 asynchronously and no stale `rsp_valid` after release.
- With `EVAL_SCHED_STATS_EN`: 5 grants to 0 and 3 to 1 -> `stat_grant0`=5, `stat_grant1`=3; forced counter 0xFFFF stays at 0xFFFF after another grant.
